// File: rtl/prv32_ex_mem_stage.sv
// EX/MEM boundary register of the prv32 pipeline: resolves conditional branches and hands a
// registered bundle to MEM over valid/ready. Define PRV32_EXMEM_SKID_EN for the two-entry skid build.
module prv32_ex_mem_stage #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [XLEN-1:0] i_ex_result,
    input  logic            i_ex_cf,
    input  logic            i_ex_zf,
    input  logic            i_ex_vf,
    input  logic            i_ex_sf,
    input  logic            i_ex_branch,
    input  logic [2:0]      i_ex_funct3,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic [XLEN-1:0] i_ex_rs2_data,
    input  logic [4:0]      i_ex_rd,
    input  logic            i_ex_regwrite,
    input  logic            i_ex_memread,
    input  logic            i_ex_memwrite,
    input  logic            i_flush,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_mem_result,
    output logic [XLEN-1:0] o_mem_store_data,
    output logic [4:0]      o_mem_rd,
    output logic [2:0]      o_mem_funct3,
    output logic            o_mem_regwrite,
    output logic            o_mem_memread,
    output logic            o_mem_memwrite,
    output logic            o_br_taken,
    output logic [XLEN-1:0] o_br_target
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] result;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
    } bundle_t;

    state_t  r_state;
    state_t  w_state_next;
    bundle_t r_main;
    bundle_t w_in;
    logic    w_accept;
    logic    w_pop;
    logic    w_load_main;
    logic    w_cond;
    logic    w_in_ready;
    logic    w_out_valid;
    logic    r_br_taken;
    logic [XLEN-1:0] r_br_target;

`ifdef PRV32_EXMEM_SKID_EN
    bundle_t r_skid;
    logic    r_in_ready;
    logic    w_load_skid;
    logic    w_skid_to_main;

    assign w_in_ready = r_in_ready;
`else
    // Without the skid entry, a new bundle can only enter when MEM drains the current one.
    assign w_in_ready = !w_out_valid | i_out_ready;
`endif

    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = i_in_valid & w_in_ready;
    assign w_pop       = w_out_valid & i_out_ready;

    always_comb begin
        w_in            = '0;
        w_in.result     = i_ex_result;
        w_in.store_data = i_ex_rs2_data;
        w_in.rd         = i_ex_rd;
        w_in.funct3     = i_ex_funct3;
        w_in.regwrite   = i_ex_regwrite;
        w_in.memread    = i_ex_memread;
        w_in.memwrite   = i_ex_memwrite;
    end

    always_comb begin
        w_cond = 1'b0;
        case (i_ex_funct3)
            3'b000:  w_cond = i_ex_zf;
            3'b001:  w_cond = !i_ex_zf;
            3'b100:  w_cond = i_ex_sf ^ i_ex_vf;
            3'b101:  w_cond = !(i_ex_sf ^ i_ex_vf);
            3'b110:  w_cond = !i_ex_cf;
            3'b111:  w_cond = i_ex_cf;
            default: w_cond = 1'b0;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_load_main  = 1'b0;
`ifdef PRV32_EXMEM_SKID_EN
        w_load_skid    = 1'b0;
        w_skid_to_main = 1'b0;
`endif
        case (r_state)
            EMPTY: begin
                if (w_accept) begin
                    w_state_next = ONE;
                    w_load_main  = 1'b1;
                end
            end
            ONE: begin
                if (w_accept && w_pop) begin
                    w_load_main = 1'b1;
                end else if (w_accept) begin
`ifdef PRV32_EXMEM_SKID_EN
                    w_state_next = TWO;
                    w_load_skid  = 1'b1;
`endif
                end else if (w_pop) begin
                    w_state_next = EMPTY;
                end
            end
`ifdef PRV32_EXMEM_SKID_EN
            TWO: begin
                if (w_pop) begin
                    w_state_next   = ONE;
                    w_skid_to_main = 1'b1;
                end
            end
`endif
            default: w_state_next = EMPTY;
        endcase
        // A flush drops whatever is held and whatever is presented this cycle.
        if (i_flush) begin
            w_state_next = EMPTY;
            w_load_main  = 1'b0;
`ifdef PRV32_EXMEM_SKID_EN
            w_load_skid    = 1'b0;
            w_skid_to_main = 1'b0;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= EMPTY;
            r_main  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_load_main) begin
                r_main <= w_in;
            end
`ifdef PRV32_EXMEM_SKID_EN
            else if (w_skid_to_main) begin
                r_main <= r_skid;
            end
`endif
        end
    end

`ifdef PRV32_EXMEM_SKID_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_skid     <= '0;
            r_in_ready <= 1'b1;
        end else begin
            if (w_load_skid) begin
                r_skid <= w_in;
            end
            r_in_ready <= (w_state_next != TWO);
        end
    end
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_br_taken  <= 1'b0;
            r_br_target <= '0;
        end else begin
            r_br_taken <= w_accept & !i_flush & i_ex_branch & w_cond;
            if (w_accept && !i_flush && i_ex_branch && w_cond) begin
                r_br_target <= i_ex_target;
            end
        end
    end

    assign o_in_ready       = w_in_ready;
    assign o_out_valid      = w_out_valid;
    assign o_mem_result     = r_main.result;
    assign o_mem_store_data = r_main.store_data;
    assign o_mem_rd         = r_main.rd;
    assign o_mem_funct3     = r_main.funct3;
    assign o_mem_regwrite   = r_main.regwrite;
    assign o_mem_memread    = r_main.memread;
    assign o_mem_memwrite   = r_main.memwrite;
    assign o_br_taken       = r_br_taken;
    assign o_br_target      = r_br_target;

endmodule
